// File: rtl/pattern_animator.sv
// rtl/pattern_animator.sv - Q10.4 pattern position/direction animator with edge bounce
// Advances the pattern once per unpaused vsync rising edge and reports wall bounces.
module pattern_animator #(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int OBJ_W    = 32,
   parameter int OBJ_H    = 32,
   parameter int X_INIT   = 100,
   parameter int Y_INIT   = 50
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync,
   input  logic        paused,
   input  logic [11:0] step_size,
   input  logic        restart,
   output logic [9:0]  pos_x,
   output logic [9:0]  pos_y,
   output logic        dir_x,
   output logic        dir_y,
   output logic        frame_tick,
   output logic [1:0]  bounce
);

   localparam logic [14:0] X_MAX = 15'((SCREEN_W - OBJ_W) << 4);
   localparam logic [14:0] Y_MAX = 15'((SCREEN_H - OBJ_H) << 4);
   localparam logic [13:0] X_RST = 14'(X_INIT << 4);
   localparam logic [13:0] Y_RST = 14'(Y_INIT << 4);

   logic [13:0] px_q, py_q;
   logic        dir_x_q, dir_y_q;
   logic        vsync_q;
   logic        frame_tick_q;
   logic [1:0]  bounce_q;
   logic        tick;
   logic [15:0] x_d, y_d;

   // Returns {bounced, new_dir, new_pos}; 15-bit math keeps pos + 4095 from wrapping.
   function automatic logic [15:0] step_axis(input logic [13:0] p, input logic d,
                                             input logic [11:0] s, input logic [14:0] maxv);
      logic [14:0] sum;
      sum = {1'b0, p} + {3'b000, s};
      if (!d) begin
         if (sum >= maxv) step_axis = {1'b1, 1'b1, maxv[13:0]};
         else             step_axis = {1'b0, 1'b0, sum[13:0]};
      end else begin
         if ({1'b0, p} <= {3'b000, s}) step_axis = {1'b1, 1'b0, 14'd0};
         else                          step_axis = {1'b0, 1'b1, p - {2'b00, s}};
      end
   endfunction

   assign tick = vsync & ~vsync_q & ~paused;

   always_comb begin
      x_d = step_axis(px_q, dir_x_q, step_size, X_MAX);
      y_d = step_axis(py_q, dir_y_q, step_size, Y_MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         px_q         <= X_RST;
         py_q         <= Y_RST;
         dir_x_q      <= 1'b0;
         dir_y_q      <= 1'b0;
         vsync_q      <= 1'b1;
         frame_tick_q <= 1'b0;
         bounce_q     <= 2'b00;
      end else begin
         vsync_q <= vsync;
         if (restart) begin
            px_q         <= X_RST;
            py_q         <= Y_RST;
            dir_x_q      <= 1'b0;
            dir_y_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            bounce_q     <= 2'b00;
         end else if (tick) begin
            px_q         <= x_d[13:0];
            dir_x_q      <= x_d[14];
            py_q         <= y_d[13:0];
            dir_y_q      <= y_d[14];
            frame_tick_q <= 1'b1;
            bounce_q     <= {y_d[15], x_d[15]};
         end else begin
            frame_tick_q <= 1'b0;
            bounce_q     <= 2'b00;
         end
      end
   end

   assign pos_x      = px_q[13:4];
   assign pos_y      = py_q[13:4];
   assign dir_x      = dir_x_q;
   assign dir_y      = dir_y_q;
   assign frame_tick = frame_tick_q;
   assign bounce     = bounce_q;

endmodule

// File: tb/tb_pattern_animator.sv
// tb/tb_pattern_animator.sv - directed self-checking bench for pattern_animator
module tb_pattern_animator;

   logic        clk = 1'b0;
   logic        rst;
   logic        vsync;
   logic        paused;
   logic [11:0] step_size;
   logic        restart;

   logic [9:0] a_px, a_py, b_px, b_py, c_px, c_py;
   logic       a_dx, a_dy, b_dx, b_dy, c_dx, c_dy;
   logic       a_ft, b_ft, c_ft;
   logic [1:0] a_bn, b_bn, c_bn;

   int errors = 0;
   int checks = 0;
   int tick_cnt = 0;
   int bad_bounce = 0;
   logic [1:0] cap_a_bn, cap_b_bn, cap_c_bn;
   logic       cap_a_ft;

   always #5 clk = ~clk;

   pattern_animator u_a (
      .clk(clk), .rst(rst), .vsync(vsync), .paused(paused), .step_size(step_size),
      .restart(restart), .pos_x(a_px), .pos_y(a_py), .dir_x(a_dx), .dir_y(a_dy),
      .frame_tick(a_ft), .bounce(a_bn));

   pattern_animator #(.X_INIT(600)) u_b (
      .clk(clk), .rst(rst), .vsync(vsync), .paused(paused), .step_size(step_size),
      .restart(restart), .pos_x(b_px), .pos_y(b_py), .dir_x(b_dx), .dir_y(b_dy),
      .frame_tick(b_ft), .bounce(b_bn));

   pattern_animator #(.X_INIT(608), .Y_INIT(448)) u_c (
      .clk(clk), .rst(rst), .vsync(vsync), .paused(paused), .step_size(step_size),
      .restart(restart), .pos_x(c_px), .pos_y(c_py), .dir_x(c_dx), .dir_y(c_dy),
      .frame_tick(c_ft), .bounce(c_bn));

   always @(negedge clk) begin
      if (a_ft) tick_cnt++;
      if (!a_ft && a_bn != 2'b00) bad_bounce++;
   end

   // One vsync period: rise, capture the cycle after, fall, settle.
   task automatic frame();
      @(negedge clk) vsync = 1'b1;
      @(negedge clk);
      cap_a_ft = a_ft;
      cap_a_bn = a_bn;
      cap_b_bn = b_bn;
      cap_c_bn = c_bn;
      @(negedge clk) vsync = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_restart();
      @(negedge clk) restart = 1'b1;
      @(negedge clk) restart = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; vsync = 1'b1; paused = 1'b0; step_size = 12'd0; restart = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (a_px !== 10'd100 || a_py !== 10'd50) begin
         errors++; $display("FAIL reset_pos: got %0d/%0d want 100/50", a_px, a_py);
      end
      checks++;
      if (a_dx !== 1'b0 || a_dy !== 1'b0 || a_ft !== 1'b0 || a_bn !== 2'b00) begin
         errors++; $display("FAIL reset_flags: got dir %b%b ft %b bn %b want 00 0 00", a_dx, a_dy, a_ft, a_bn);
      end
      checks++;
      if (tick_cnt !== 0) begin
         errors++; $display("FAIL reset_no_tick: got %0d ticks want 0", tick_cnt);
      end
      @(negedge clk) vsync = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_step16();
      int t0;
      step_size = 12'd16;
      t0 = tick_cnt;
      frame();
      checks++;
      if (cap_a_ft !== 1'b1) begin
         errors++; $display("FAIL tick_latency: got frame_tick %b want 1", cap_a_ft);
      end
      frame();
      frame();
      checks++;
      if (a_px !== 10'd103 || a_py !== 10'd53) begin
         errors++; $display("FAIL step16_pos: got %0d/%0d want 103/53", a_px, a_py);
      end
      checks++;
      if (tick_cnt - t0 !== 3) begin
         errors++; $display("FAIL step16_ticks: got %0d want 3", tick_cnt - t0);
      end
      checks++;
      if (cap_a_bn !== 2'b00) begin
         errors++; $display("FAIL step16_bounce: got %b want 00", cap_a_bn);
      end
   endtask

   task automatic test_fraction();
      do_restart();
      step_size = 12'd2;
      repeat (7) frame();
      checks++;
      if (a_px !== 10'd100 || a_py !== 10'd50) begin
         errors++; $display("FAIL frac7: got %0d/%0d want 100/50", a_px, a_py);
      end
      frame();
      checks++;
      if (a_px !== 10'd101 || a_py !== 10'd51) begin
         errors++; $display("FAIL frac8: got %0d/%0d want 101/51", a_px, a_py);
      end
   endtask

   task automatic test_bounce_x();
      logic [9:0] exp_seq [7];
      exp_seq = '{10'd601, 10'd603, 10'd604, 10'd606, 10'd607, 10'd608, 10'd606};
      do_restart();
      step_size = 12'd24;
      for (int i = 0; i < 7; i++) begin
         frame();
         checks++;
         if (b_px !== exp_seq[i]) begin
            errors++; $display("FAIL bounce_seq[%0d]: got %0d want %0d", i, b_px, exp_seq[i]);
         end
         if (i == 5) begin
            checks++;
            if (b_dx !== 1'b1 || cap_b_bn !== 2'b01) begin
               errors++; $display("FAIL bounce_hit: got dir %b bn %b want 1 01", b_dx, cap_b_bn);
            end
         end
         if (i == 6) begin
            checks++;
            if (b_dx !== 1'b1 || cap_b_bn !== 2'b00) begin
               errors++; $display("FAIL bounce_after: got dir %b bn %b want 1 00", b_dx, cap_b_bn);
            end
         end
      end
   endtask

   task automatic test_paused();
      int t0;
      do_restart();
      paused = 1'b1;
      t0 = tick_cnt;
      repeat (5) frame();
      checks++;
      if (a_px !== 10'd100 || a_py !== 10'd50 || tick_cnt !== t0) begin
         errors++; $display("FAIL paused_hold: got %0d/%0d ticks %0d want 100/50 ticks %0d", a_px, a_py, tick_cnt, t0);
      end
      @(negedge clk) vsync = 1'b1;
      @(negedge clk) paused = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (tick_cnt !== t0 || a_px !== 10'd100) begin
         errors++; $display("FAIL unpause_high: got ticks %0d px %0d want %0d 100", tick_cnt, a_px, t0);
      end
      @(negedge clk) vsync = 1'b0;
      @(negedge clk);
      frame();
      checks++;
      if (tick_cnt !== t0 + 1 || a_px !== 10'd101 || a_py !== 10'd51) begin
         errors++; $display("FAIL unpause_edge: got ticks %0d pos %0d/%0d want %0d 101/51", tick_cnt, a_px, a_py, t0 + 1);
      end
   endtask

   task automatic test_restart_corner();
      frame();
      @(negedge clk) begin vsync = 1'b1; restart = 1'b1; end
      @(negedge clk) restart = 1'b0;
      checks++;
      if (a_px !== 10'd100 || a_py !== 10'd50 || a_dx !== 1'b0 || a_dy !== 1'b0) begin
         errors++; $display("FAIL restart_pos: got %0d/%0d dir %b%b want 100/50 00", a_px, a_py, a_dx, a_dy);
      end
      checks++;
      if (a_ft !== 1'b0 || a_bn !== 2'b00) begin
         errors++; $display("FAIL restart_tick: got ft %b bn %b want 0 00", a_ft, a_bn);
      end
      @(negedge clk) vsync = 1'b0;
      @(negedge clk);
      step_size = 12'd0;
      frame();
      checks++;
      if (cap_c_bn !== 2'b11 || c_dx !== 1'b1 || c_dy !== 1'b1) begin
         errors++; $display("FAIL corner: got bn %b dir %b%b want 11 11", cap_c_bn, c_dx, c_dy);
      end
      checks++;
      if (c_px !== 10'd608 || c_py !== 10'd448) begin
         errors++; $display("FAIL corner_pos: got %0d/%0d want 608/448", c_px, c_py);
      end
      checks++;
      if (cap_a_bn !== 2'b00 || a_px !== 10'd100 || a_dx !== 1'b0) begin
         errors++; $display("FAIL step0_mid: got bn %b px %0d dir %b want 00 100 0", cap_a_bn, a_px, a_dx);
      end
      checks++;
      if (bad_bounce !== 0) begin
         errors++; $display("FAIL bounce_without_tick: got %0d want 0", bad_bounce);
      end
   endtask

   initial begin
      test_reset();
      test_step16();
      test_fraction();
      test_bounce_x();
      test_paused();
      test_restart_corner();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
